mdc_arbiter: RTL

//  Shares one MDC (GCD) core between NREQ requesters. Picks a requester round-robin,

---
 rtl/mdc_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mdc_arbiter.sv
// mdc_arbiter: round-robin arbiter that shares a single MDC (GCD) core between
// NREQ requesters. The winner's operands are latched, the core is started and
// the result is handed back with a one-cycle ack.
// Optional feature: define MDC_ARB_TIMEOUT_EN to abort a RUN that lasts TIMEOUT
// cycles without core_done (result forced to 0, err raised with the ack).
module mdc_arbiter #(
    parameter int WIDTH   = 8,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   a_in,
    input  logic [NREQ*WIDTH-1:0]   b_in,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         ack,
    output logic [WIDTH-1:0]        result,
    output logic                    err,
    output logic                    busy,
    output logic                    core_start,
    output logic [WIDTH-1:0]        core_a,
    output logic [WIDTH-1:0]        core_b,
    input  logic                    core_done,
    input  logic [WIDTH-1:0]        core_result
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IW-1:0]   LAST_IDX = IW'(NREQ - 1);
    localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

    // Reject parameter values outside the supported range at elaboration.
    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_param
        $error("mdc_arbiter: NREQ must be 2..8 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        ACK   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   win_idx;
    logic            win_valid;
    logic [IW-1:0]   next_ptr;

`ifdef MDC_ARB_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
    logic [CW-1:0] tmo_cnt;
    logic          err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Round-robin pick: first requesting client found scanning upward from ptr.
    always_comb begin
        int j;
        j         = 0;
        win_idx   = '0;
        win_valid = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            j = (int'(ptr) + i) % NREQ;
            if (!win_valid && req[j]) begin
                win_valid = 1'b1;
                win_idx   = IW'(j);
            end
        end
    end

    // The client after the one just served becomes the highest priority.
    assign next_ptr = (idx == LAST_IDX) ? '0 : idx + 1'b1;

    // Arbitration/handshake FSM; every output is a register updated here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            ptr        <= '0;
            idx        <= '0;
            gnt        <= '0;
            ack        <= '0;
            result     <= '0;
            busy       <= 1'b0;
            core_start <= 1'b0;
            core_a     <= '0;
            core_b     <= '0;
`ifdef MDC_ARB_TIMEOUT_EN
            tmo_cnt    <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    gnt        <= '0;
                    ack        <= '0;
                    busy       <= 1'b0;
                    core_start <= 1'b0;
                    if (win_valid) begin
                        idx        <= win_idx;
                        core_a     <= a_in[win_idx*WIDTH +: WIDTH];
                        core_b     <= b_in[win_idx*WIDTH +: WIDTH];
                        gnt        <= ONE_HOT0 << win_idx;
                        busy       <= 1'b1;
                        core_start <= 1'b1;
                        state      <= RUN;
`ifdef MDC_ARB_TIMEOUT_EN
                        tmo_cnt    <= '0;
`endif
                    end
                end
                RUN: begin
                    if (core_done) begin
                        result     <= core_result;
                        ack        <= ONE_HOT0 << idx;
                        core_start <= 1'b0;
                        state      <= ACK;
`ifdef MDC_ARB_TIMEOUT_EN
                        err_q      <= 1'b0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        result     <= '0;
                        err_q      <= 1'b1;
                        ack        <= ONE_HOT0 << idx;
                        core_start <= 1'b0;
                        state      <= ACK;
                    end else begin
                        tmo_cnt    <= tmo_cnt + 1'b1;
`endif
                    end
                end
                ACK: begin
                    ack   <= '0;
                    gnt   <= '0;
                    ptr   <= next_ptr;
                    state <= DRAIN;
                end
                DRAIN: begin
                    if (!core_done) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    gnt        <= '0;
                    ack        <= '0;
                    busy       <= 1'b0;
                    core_start <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule
